fetch_unit: RTL and testbench

- Instruction fetch stage that drives the upstream side of the decoder's valid/ready handshake.
- Maintains the PC, issues single-outstanding word reads to instruction memory, and buffers returned words with their addresses in a small FIFO.
- Supports redirects from execute for branches and jumps. Reports a sticky fault on misalignment or memory error.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one read in flight to instruction
// memory and buffers returned words with their addresses toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic        clock,
  input  logic        nreset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_address,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_error,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [31:0] decode_instruction,
  output logic [31:0] decode_address,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic        fault,
  output logic [31:0] fault_address
);

  localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    ST_REQUEST = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fetch_entry_t;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               discard_q, discard_d;
  logic               fault_q, fault_d;
  logic [31:0]        fault_addr_q, fault_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  fetch_entry_t       fifo_q [BUFFER_DEPTH];

  logic req_fire, redir_take, outstanding, pop, push, flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A request only goes out when its response is guaranteed a FIFO slot.
  assign mem_req_valid      = nreset && (state_q == ST_REQUEST) && (count_q < DEPTH_CNT);
  assign mem_req_address    = pc_q;
  assign decode_valid       = (count_q != '0);
  assign decode_instruction = fifo_q[rd_ptr_q].instr;
  assign decode_address     = fifo_q[rd_ptr_q].addr;
  assign fault              = fault_q;
  assign fault_address      = fault_addr_q;

  assign req_fire    = mem_req_valid && mem_req_ready;
  assign redir_take  = redirect_valid && !fault_q && (state_q != ST_FAULT);
  assign outstanding = ((state_q == ST_WAIT) && !mem_resp_valid) || req_fire;
  assign pop         = decode_valid && decode_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    push         = 1'b0;
    flush        = 1'b0;
    if (redir_take) begin
      flush     = 1'b1;
      pc_d      = redirect_address;
      discard_d = outstanding;
      state_d   = outstanding ? ST_WAIT : ST_REQUEST;
      if (redirect_address[1:0] != 2'b00) begin
        fault_d      = 1'b1;
        fault_addr_d = redirect_address;
        // With a read still in flight, wait out its response before halting.
        if (!outstanding) state_d = ST_FAULT;
      end
    end else begin
      case (state_q)
        ST_REQUEST: if (req_fire) state_d = ST_WAIT;
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = fault_q ? ST_FAULT : ST_REQUEST;
            end else if (mem_resp_error) begin
              fault_d      = 1'b1;
              fault_addr_d = pc_q;
              state_d      = ST_FAULT;
            end else begin
              push    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = ST_REQUEST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_REQUEST;
      pc_q         <= RESET_VECTOR;
      discard_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{instr: mem_resp_data, addr: pc_q};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed multi-cycle corner cases and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clock, nreset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_address;
  logic        mem_resp_valid, mem_resp_error;
  logic [31:0] mem_resp_data;
  logic        decode_valid, decode_ready;
  logic [31:0] decode_instruction, decode_address;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        fault;
  logic [31:0] fault_address;

  fetch_unit #(.RESET_VECTOR(32'h0), .BUFFER_DEPTH(DEPTH)) dut (
    .clock(clock), .nreset(nreset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_address(mem_req_address),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_error(mem_resp_error),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .decode_instruction(decode_instruction), .decode_address(decode_address),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .fault(fault), .fault_address(fault_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_2468;
  endfunction

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        rerr, dr, redv;
    logic [31:0] reda;
    logic        e_reqv;
    logic [31:0] e_reqa;
    logic        e_dv;
    logic [31:0] e_da, e_di;
    logic        e_fault;
  } vec_t;

  function automatic vec_t mk(input logic rdy, rv, input logic [31:0] rdata, input logic dr, redv,
                              input logic [31:0] reda, input logic e_reqv, input logic [31:0] e_reqa,
                              input logic e_dv, input logic [31:0] e_da);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = 1'b0; v.dr = dr; v.redv = redv; v.reda = reda;
    v.e_reqv = e_reqv; v.e_reqa = e_reqa; v.e_dv = e_dv; v.e_da = e_da; v.e_di = word(e_da);
    v.e_fault = 1'b0;
    return v;
  endfunction

  // Bench-side memory for directed sequences: answers 'delay' cycles after acceptance.
  logic        pend;
  int          pcnt, delay;
  logic [31:0] paddr, err_addr, stall_addr;
  logic        err_en;
  logic        s_dv, s_rv, s_f;
  logic [31:0] s_da, s_di, s_ra, s_fa;
  logic [31:0] got[$];

  task automatic idle_inputs();
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_error = 0;
    decode_ready = 0; redirect_valid = 0; redirect_address = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    nreset = 0;
    idle_inputs();
    pend = 0; pcnt = 0; delay = 1; err_en = 0; stall_addr = 32'hFFFF_FFFF; s_f = 0;
    got.delete();
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 0);
    chk("rst_dec_valid", {31'b0, decode_valid}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_fault_addr", fault_address, 0);
    @(negedge clock);
    nreset = 1;
  endtask

  task automatic cyc(input logic rdy, input logic dr, input logic redv, input logic [31:0] reda);
    @(negedge clock);
    s_dv = decode_valid; s_da = decode_address; s_di = decode_instruction;
    s_rv = mem_req_valid; s_ra = mem_req_address; s_f = fault; s_fa = fault_address;
    mem_req_ready    = rdy;
    redirect_valid   = redv;
    redirect_address = reda;
    mem_resp_valid   = pend && (pcnt == 0);
    mem_resp_data    = word(paddr);
    mem_resp_error   = pend && (pcnt == 0) && err_en && (paddr == err_addr);
    decode_ready     = dr && !(s_dv && s_da == stall_addr);
    if (s_dv && decode_ready) begin
      got.push_back(s_da);
      chk("dec_word", s_di, word(s_da));
    end
    @(posedge clock);
    if (pend) begin
      if (pcnt == 0) pend = 0;
      else pcnt--;
    end
    if (s_rv && rdy) begin
      pend = 1; paddr = s_ra; pcnt = delay - 1;
    end
  endtask

  // Reference model: occupancy queue plus in-flight/drop/fault flags.
  logic [31:0] m_pc, m_faddr;
  logic        m_inflight, m_drop, m_fault;
  logic [31:0] mq_a[$], mq_d[$];

  task automatic model_reset();
    m_pc = 32'h0; m_faddr = 0; m_inflight = 0; m_drop = 0; m_fault = 0;
    mq_a.delete(); mq_d.delete();
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic rerr, input logic [31:0] rdata,
                            input logic dr, input logic redv, input logic [31:0] reda);
    logic fire, resp, pop, outst;
    fire = !m_fault && !m_inflight && (mq_a.size() < DEPTH) && rdy;
    resp = m_inflight && rv;
    pop  = (mq_a.size() > 0) && dr;
    if (redv && !m_fault) begin
      outst = (m_inflight && !rv) || fire;
      mq_a.delete(); mq_d.delete();
      m_pc = reda; m_inflight = outst; m_drop = outst;
      if (reda[1:0] != 2'b00) begin m_fault = 1; m_faddr = reda; end
    end else begin
      if (pop) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
      if (fire) m_inflight = 1;
      else if (resp) begin
        m_inflight = 0;
        if (m_drop) m_drop = 0;
        else if (rerr) begin m_fault = 1; m_faddr = m_pc; end
        else begin mq_a.push_back(m_pc); mq_d.push_back(rdata); m_pc = m_pc + 4; end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   reqs, seen;
    logic [31:0] first_ra;
    logic hit;

    nreset = 0;
    idle_inputs();

    // Straight-line fetch with 1-cycle memory, then a redirect that swallows a response.
    tbl[0]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h0,  0, 0);
    tbl[1]  = mk(0, 1, word(0),   1, 0, 0,     0, 0,      0, 0);
    tbl[2]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h4,  1, 32'h0);
    tbl[3]  = mk(0, 1, word(4),   1, 0, 0,     0, 0,      0, 0);
    tbl[4]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h8,  1, 32'h4);
    tbl[5]  = mk(0, 1, word(8),   1, 0, 0,     0, 0,      0, 0);
    tbl[6]  = mk(1, 0, 0,         1, 0, 0,     1, 32'hC,  1, 32'h8);
    tbl[7]  = mk(0, 1, word(12),  1, 0, 0,     0, 0,      0, 0);
    tbl[8]  = mk(0, 0, 0,         1, 0, 0,     1, 32'h10, 1, 32'hC);
    tbl[9]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h10, 0, 0);
    tbl[10] = mk(0, 1, word(16),  1, 1, 32'h40, 0, 0,     0, 0);
    tbl[11] = mk(0, 0, 0,         1, 0, 0,     1, 32'h40, 0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      mem_req_ready = tbl[i].rdy; mem_resp_valid = tbl[i].rv; mem_resp_data = tbl[i].rdata;
      mem_resp_error = tbl[i].rerr; decode_ready = tbl[i].dr;
      redirect_valid = tbl[i].redv; redirect_address = tbl[i].reda;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, mem_req_valid}, {31'b0, tbl[i].e_reqv});
      if (tbl[i].e_reqv) chk($sformatf("tbl%0d_req_addr", i), mem_req_address, tbl[i].e_reqa);
      chk($sformatf("tbl%0d_dec_valid", i), {31'b0, decode_valid}, {31'b0, tbl[i].e_dv});
      if (tbl[i].e_dv) begin
        chk($sformatf("tbl%0d_dec_addr", i), decode_address, tbl[i].e_da);
        chk($sformatf("tbl%0d_dec_instr", i), decode_instruction, tbl[i].e_di);
      end
      chk($sformatf("tbl%0d_fault", i), {31'b0, fault}, {31'b0, tbl[i].e_fault});
    end

    // Backpressure: decoder stalled, FIFO fills to depth, then drains in order.
    do_reset();
    repeat (10) cyc(1, 0, 0, 0);
    chk("bp_dec_valid", {31'b0, s_dv}, 1);
    chk("bp_head_addr", s_da, 32'h0);
    chk("bp_req_blocked", {31'b0, s_rv}, 0);
    got.delete();
    for (int i = 0; i < 30 && got.size() < 3; i++) cyc(1, 1, 0, 0);
    chk("bp_drain_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 32'h0);
      chk("bp_order1", got[1], 32'h4);
      chk("bp_order2", got[2], 32'h8);
    end

    // Redirect while waiting on the response for 0x8.
    do_reset();
    delay = 3;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc(1, 1, 0, 0);
      hit = s_rv && (s_ra == 32'h8);
    end
    chk("rif_reached_8", {31'b0, hit}, 1);
    cyc(1, 0, 1, 32'h100);
    got.delete();
    cyc(1, 1, 0, 0);
    chk("rif_flush_dv", {31'b0, s_dv}, 0);
    chk("rif_wait_reqv", {31'b0, s_rv}, 0);
    seen = 0; first_ra = '1;
    for (int i = 0; i < 60 && got.size() < 2; i++) begin
      cyc(1, 1, 0, 0);
      if (s_rv && seen == 0) begin first_ra = s_ra; seen = 1; end
    end
    chk("rif_first_req", first_ra, 32'h100);
    chk("rif_pop_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("rif_first_dec", got[0], 32'h100);
      chk("rif_second_dec", got[1], 32'h104);
    end

    // Redirect in the same cycle as a pop and a response.
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h200);
    chk("rpr_head_present", {31'b0, s_dv}, 1);
    got.delete();
    cyc(0, 1, 0, 0);
    chk("rpr_empty", {31'b0, s_dv}, 0);
    chk("rpr_req_valid", {31'b0, s_rv}, 1);
    chk("rpr_req_addr", s_ra, 32'h200);
    for (int i = 0; i < 20 && got.size() < 1; i++) cyc(1, 1, 0, 0);
    chk("rpr_first_dec", (got.size() > 0) ? got[0] : 32'hDEAD_DEAD, 32'h200);

    // Memory error at 0x10 with 0xC held at the head.
    do_reset();
    err_en = 1; err_addr = 32'h10; stall_addr = 32'hC;
    for (int i = 0; i < 40 && !s_f; i++) cyc(1, 1, 0, 0);
    chk("err_fault", {31'b0, s_f}, 1);
    chk("err_fault_addr", s_fa, 32'h10);
    chk("err_head_valid", {31'b0, s_dv}, 1);
    chk("err_head_addr", s_da, 32'hC);
    chk("err_popped", got.size(), 3);
    stall_addr = 32'hFFFF_FFFF;
    reqs = 0;
    repeat (10) begin cyc(1, 1, 0, 0); reqs += int'(s_rv); end
    chk("err_no_reqs", reqs, 0);
    chk("err_drained", got.size(), 4);
    chk("err_last_dec", got[got.size()-1], 32'hC);

    // Misaligned redirect while idle in REQUEST; later redirects ignored.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h102);
    cyc(1, 1, 1, 32'h100);
    chk("mis_fault", {31'b0, s_f}, 1);
    chk("mis_fault_addr", s_fa, 32'h102);
    chk("mis_reqv", {31'b0, s_rv}, 0);
    reqs = 0;
    repeat (6) begin cyc(1, 1, 0, 0); reqs += int'(s_rv); end
    chk("mis_no_reqs", reqs, 0);
    chk("mis_fault_addr_held", s_fa, 32'h102);

    // Misaligned redirect with a read in flight, then nreset pulse mid-WAIT.
    do_reset();
    delay = 5;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 32'h302);
    cyc(1, 1, 0, 0);
    chk("misw_fault", {31'b0, s_f}, 1);
    chk("misw_fault_addr", s_fa, 32'h302);
    chk("misw_reqv", {31'b0, s_rv}, 0);
    @(negedge clock);
    nreset = 0;
    idle_inputs();
    #1;
    chk("prst_fault", {31'b0, fault}, 0);
    chk("prst_reqv", {31'b0, mem_req_valid}, 0);
    @(negedge clock);
    nreset = 1; pend = 0;
    cyc(0, 1, 0, 0);
    chk("prst_req_valid", {31'b0, s_rv}, 1);
    chk("prst_req_addr", s_ra, 32'h0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    begin
      int flt_cyc = 0;
      logic rdy, rv, rerr, dr, redv;
      logic [31:0] rdata, reda;
      logic [31:0] exp_rv;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clock);
        if ((m_fault && flt_cyc > 5) || ($urandom_range(399) == 0)) begin
          nreset = 0;
          idle_inputs();
          #1;
          chk("rnd_rst_reqv", {31'b0, mem_req_valid}, 0);
          chk("rnd_rst_dv", {31'b0, decode_valid}, 0);
          chk("rnd_rst_fault", {31'b0, fault}, 0);
          model_reset();
          flt_cyc = 0;
          continue;
        end
        nreset = 1;
        rdy   = ($urandom_range(3) != 0);
        dr    = ($urandom_range(3) != 0);
        rv    = m_inflight ? ($urandom_range(1) == 0) : ($urandom_range(7) == 0);
        rerr  = ($urandom_range(39) == 0);
        rdata = $urandom;
        redv  = ($urandom_range(14) == 0);
        reda  = $urandom & 32'h0000_FFFC;
        if ($urandom_range(4) == 0) reda[1:0] = 2'($urandom_range(3, 1));
        mem_req_ready = rdy; decode_ready = dr; mem_resp_valid = rv; mem_resp_error = rerr;
        mem_resp_data = rdata; redirect_valid = redv; redirect_address = reda;
        #1;
        exp_rv = {31'b0, !m_fault && !m_inflight && (mq_a.size() < DEPTH)};
        chk("rnd_req_valid", {31'b0, mem_req_valid}, exp_rv);
        if (exp_rv[0]) chk("rnd_req_addr", mem_req_address, m_pc);
        chk("rnd_dec_valid", {31'b0, decode_valid}, {31'b0, mq_a.size() > 0});
        if (mq_a.size() > 0) begin
          chk("rnd_dec_addr", decode_address, mq_a[0]);
          chk("rnd_dec_instr", decode_instruction, mq_d[0]);
        end
        chk("rnd_fault", {31'b0, fault}, {31'b0, m_fault});
        chk("rnd_fault_addr", fault_address, m_faddr);
        @(posedge clock);
        model_step(rdy, rv, rerr, rdata, dr, redv, reda);
        if (m_fault) flt_cyc++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
